// File: rtl/regfile_sb.sv
// regfile_sb: register file with write bypass and per-register saturating pending-write scoreboard
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic                     iss_ready_o,
  output logic                     wb_err_o
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [1:0]        pend_q [DEPTH];
  logic [1:0]        pend_d [DEPTH];
  logic [DEPTH-1:0]  inc, dec;
  logic              wb_err_q, wb_err_d, wr_ok, iss_fire;
  // register 0 never takes data or pending counts when hardwired
  assign wr_ok       = wr_en_i && !(ZERO_REG != 0 && wr_addr_i == '0);
  assign iss_ready_o = reset && !(pend_q[iss_addr_i] == 2'd3 && !(wr_en_i && wr_addr_i == iss_addr_i));
  assign iss_fire    = iss_valid_i && iss_ready_o && !(ZERO_REG != 0 && iss_addr_i == '0);
  assign wb_err_o    = wb_err_q;
  always_comb begin
    inc = '0;
    dec = '0;
    inc[iss_addr_i] = iss_fire;
    dec[wr_addr_i]  = wr_ok;
    wb_err_d = wb_err_q;
    for (int r = 0; r < DEPTH; r++) begin
      pend_d[r] = (inc[r] && !dec[r]) ? pend_q[r] + 2'd1 :
                  (dec[r] && !inc[r] && pend_q[r] != 2'd0) ? pend_q[r] - 2'd1 : pend_q[r];
      wb_err_d  = wb_err_d | (dec[r] && !inc[r] && pend_q[r] == 2'd0);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r]  <= '0;
        pend_q[r] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      if (wr_ok) mem_q[wr_addr_i] <= wr_data_i;
      pend_q   <= pend_d;
      wb_err_q <= wb_err_d;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero, hit;
    assign a    = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG != 0 && a == '0;
    assign hit  = BYPASS != 0 && wr_en_i && wr_addr_i == a && !zero;
    assign rd_data_o[k*DATA_W +: DATA_W] = (!reset || zero) ? '0 : hit ? wr_data_i : mem_q[a];
    // the landing writeback retires the last producer this cycle
    assign rd_busy_o[k] = reset && !zero && pend_q[a] != 2'd0 && !(hit && pend_q[a] == 2'd1);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector table plus directed sequences for bypass and mid-run reset
module tb_regfile_sb;
  logic        clk = 1'b0, reset = 1'b0;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_data;
  logic [1:0]  rd_busy, nb_busy;
  logic        wr_en, iss_valid, iss_ready, wb_err, nb_ready, nb_err;
  logic [4:0]  wr_addr, iss_addr;
  logic [31:0] wr_data;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  regfile_sb dut (.clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .iss_ready_o(iss_ready), .wb_err_o(wb_err));

  regfile_sb #(.BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(nb_data),
    .rd_busy_o(nb_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .iss_ready_o(nb_ready), .wb_err_o(nb_err));

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia, ra0, ra1;
    logic [31:0] d0, d1;
    logic [1:0]  busy;
    logic        rdy, err;
  } vec_t;
  vec_t v[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en = we; wr_addr = wa; wr_data = wd; iss_valid = iv; iss_addr = ia; rd_addr = {ra1, ra0};
  endtask

  initial begin
    v[0]  = '{0, 0, 32'h0,        1, 5, 5,  3,  32'h0,        32'h0,        2'b00, 1, 0};
    v[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b00, 1, 0};
    v[2]  = '{0, 0, 32'h0,        0, 0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0};
    v[3]  = '{0, 0, 32'h0,        1, 3, 3,  5,  32'h0,        32'hDEADBEEF, 2'b00, 1, 0};
    v[4]  = '{0, 0, 32'h0,        1, 3, 3,  5,  32'h0,        32'hDEADBEEF, 2'b01, 1, 0};
    v[5]  = '{0, 0, 32'h0,        1, 3, 3,  5,  32'h0,        32'hDEADBEEF, 2'b01, 1, 0};
    v[6]  = '{0, 0, 32'h0,        1, 3, 3,  5,  32'h0,        32'hDEADBEEF, 2'b01, 0, 0};
    v[7]  = '{1, 3, 32'h33,       1, 3, 3,  5,  32'h33,       32'hDEADBEEF, 2'b01, 1, 0};
    v[8]  = '{0, 0, 32'h0,        0, 3, 3,  3,  32'h33,       32'h33,       2'b11, 0, 0};
    v[9]  = '{1, 3, 32'h34,       0, 0, 3,  0,  32'h34,       32'h0,        2'b01, 1, 0};
    v[10] = '{1, 3, 32'h35,       0, 0, 3,  3,  32'h35,       32'h35,       2'b11, 1, 0};
    v[11] = '{1, 3, 32'h36,       0, 0, 3,  3,  32'h36,       32'h36,       2'b00, 1, 0};
    v[12] = '{0, 0, 32'h0,        0, 0, 3,  5,  32'h36,       32'hDEADBEEF, 2'b00, 1, 0};
    v[13] = '{0, 0, 32'h0,        1, 9, 9,  3,  32'h0,        32'h36,       2'b00, 1, 0};
    v[14] = '{1, 9, 32'h99,       1, 9, 9,  3,  32'h99,       32'h36,       2'b00, 1, 0};
    v[15] = '{0, 0, 32'h0,        0, 0, 9,  9,  32'h99,       32'h99,       2'b11, 1, 0};
    v[16] = '{1, 9, 32'h9A,       0, 0, 9,  0,  32'h9A,       32'h0,        2'b00, 1, 0};
    v[17] = '{1, 0, 32'h12345678, 1, 0, 0,  0,  32'h0,        32'h0,        2'b00, 1, 0};
    v[18] = '{0, 0, 32'h0,        0, 0, 0,  9,  32'h0,        32'h9A,       2'b00, 1, 0};
    v[19] = '{1, 10, 32'hAAAA,    0, 0, 10, 0,  32'hAAAA,     32'h0,        2'b00, 1, 0};
    v[20] = '{0, 0, 32'h0,        0, 0, 10, 10, 32'hAAAA,     32'hAAAA,     2'b00, 1, 1};
    v[21] = '{0, 0, 32'h0,        1, 0, 5,  3,  32'hDEADBEEF, 32'h36,       2'b00, 1, 1};

    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("ready_in_reset", {31'b0, iss_ready}, 32'h0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 5'(a), 5'(a), 5'(31 - a));
      #1;
      chk($sformatf("rst_data0[%0d]", a), rd_data[31:0], 32'h0);
      chk($sformatf("rst_data1[%0d]", a), rd_data[63:32], 32'h0);
      chk($sformatf("rst_busy[%0d]", a), {30'b0, rd_busy}, 32'h0);
      chk($sformatf("rst_ready[%0d]", a), {31'b0, iss_ready}, 32'h1);
    end
    chk("rst_err", {31'b0, wb_err}, 32'h0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(v[i].we, v[i].wa, v[i].wd, v[i].iv, v[i].ia, v[i].ra0, v[i].ra1);
      #1;
      chk($sformatf("v%0d_data0", i), rd_data[31:0], v[i].d0);
      chk($sformatf("v%0d_data1", i), rd_data[63:32], v[i].d1);
      chk($sformatf("v%0d_busy", i), {30'b0, rd_busy}, {30'b0, v[i].busy});
      chk($sformatf("v%0d_ready", i), {31'b0, iss_ready}, {31'b0, v[i].rdy});
      chk($sformatf("v%0d_err", i), {31'b0, wb_err}, {31'b0, v[i].err});
    end

    @(negedge clk) drive(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);
    #1;
    chk("byp_on_r7", rd_data[31:0], 32'hA5A5A5A5);
    chk("byp_off_r7", nb_data[31:0], 32'h0);
    @(negedge clk) drive(0, 0, 0, 0, 0, 7, 7);
    #1;
    chk("byp_off_r7_next", nb_data[31:0], 32'hA5A5A5A5);
    chk("byp_on_r7_next", rd_data[63:32], 32'hA5A5A5A5);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk) drive(0, 0, 0, 1, 4, 4, 0);
    end
    @(negedge clk) drive(1, 4, 32'h55, 0, 0, 4, 0);
    @(negedge clk) drive(0, 0, 0, 0, 4, 4, 4);
    #1;
    chk("pre_rst_r4", rd_data[31:0], 32'h55);
    chk("pre_rst_busy", {30'b0, rd_busy}, 32'h3);
    chk("pre_rst_ready", {31'b0, iss_ready}, 32'h1);
    chk("pre_rst_err", {31'b0, wb_err}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_r4", rd_data[31:0], 32'h0);
    chk("mid_rst_busy", {30'b0, rd_busy}, 32'h0);
    chk("mid_rst_err", {31'b0, wb_err}, 32'h0);
    chk("mid_rst_ready", {31'b0, iss_ready}, 32'h0);
    @(posedge clk) #1;
    chk("held_rst_ready", {31'b0, iss_ready}, 32'h0);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, iss_ready}, 32'h1);
    chk("post_rst_r4", rd_data[31:0], 32'h0);
    chk("post_rst_busy", {30'b0, rd_busy}, 32'h0);
    @(negedge clk) drive(0, 0, 0, 0, 0, 5, 7);
    #1;
    chk("post_rst_r5", rd_data[31:0], 32'h0);
    chk("post_rst_r7", rd_data[63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a built-in pending-write scoreboard, sitting in the decode/writeback stages of the MIPS datapath. It has configurable data width, depth and read-port count, a synchronous write port and optional write-to-read bypass. A per-register saturating pending counter is set by instruction issue and cleared by writeback, so the pipeline can detect RAW hazards. Issue is flow-controlled with a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing
- rd_busy  out  NUM_RD  1 = register has an outstanding producer
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- iss_valid  in  1  issuing instruction will write iss_addr
- iss_addr  in  ADDR_W  destination of issuing instruction
- iss_ready  out  1  issue accepted this cycle when high
- wb_err  out  1  sticky: writeback to a register with pending count 0

## Operation
- Storage: 2**ADDR_W x DATA_W array plus one 2-bit pending counter per register.
- Write: at the clock edge with wr_en=1, array[wr_addr] <= wr_data. Ignored when ZERO_REG=1 and wr_addr=0.
- Read: combinational per port. If ZERO_REG=1 and rd_addr=0, the port returns 0.
- Bypass: when BYPASS=1, wr_en=1 and wr_addr equals rd_addr (nonzero if ZERO_REG), the port returns wr_data; otherwise it returns the array contents.
- Issue handshake: a transfer occurs when iss_valid and iss_ready are both 1.
  - iss_ready = 0 when pend[iss_addr] = 3 with no same-cycle writeback to iss_addr; otherwise 1.
  - iss_ready is a function of the current state and the wr_* inputs only, never of iss_valid.
  - iss_addr=0 with ZERO_REG=1: always ready, counter not touched.
- Counter update per register at the clock edge:
  - issue transfer only: +1
  - writeback only: −1, saturating at 0
  - both in the same cycle: unchanged
- Writeback with pend = 0 and no same-cycle issue to that address: data is written, count stays 0, wb_err is set. wb_err clears only on reset.
- rd_busy[k] = (pend[rd_addr_k] != 0), except it reads 0 when a bypass hit occurs and pend = 1. Forced 0 for register 0 when ZERO_REG=1.

## Timing
- Reset (async, while reset=0):
  - all registers 0, all counters 0, wb_err 0
  - rd_data 0, rd_busy 0
  - iss_ready forced 0 while reset is low, 1 from the first cycle after release
- Write latency: 1 cycle through the array; 0 cycles through the bypass.
- Counter latency: an issue at edge N makes rd_busy visible in cycle N+1.
- Reset asserted mid-operation discards all pending counts and data immediately. No partial update completes.
- No multi-cycle state. All outputs are derived from the current state plus same-cycle inputs.

## Test plan
- Reset, then read all addresses on every port -> rd_data = 0, rd_busy = 0, iss_ready = 1, wb_err = 0.
- Write 0xDEADBEEF to r5; read r5 next cycle -> 0xDEADBEEF. Write 0x12345678 to r0 -> r0 reads 0.
- BYPASS=1: wr_en to r7 with 0xA5A5A5A5 while rd_addr = 7 in the same cycle -> rd_data = 0xA5A5A5A5. With BYPASS=0 -> old value returned.
- Issue r3 three times -> rd_busy = 1 and iss_ready = 0 for r3. A fourth issue is held until a writeback to r3 lands in the same cycle, then it is accepted and the count stays 3.
- Issue r9 and write back r9 in the same cycle with pend = 1 -> count stays 1. A writeback to r10 with pend = 0 -> wb_err = 1 and the data is written.
- With pend[r4] = 2 and r4 = 0x55, assert reset mid-run -> immediately r4 reads 0, rd_busy = 0, wb_err = 0, iss_ready = 0 until reset is released.
